hatch_obi_arbiter: RTL

// - 2:1 OBI arbiter downstream of the hatch core: merges the instruction fetch port and the data port onto one shared memory port.
// - Round-robin arbitration with request locking until grant.
// - Tracks in-flight transactions in a source-ID FIFO so in-order responses are routed back to the issuing port.
// - Sits between hatch_core and the single-port system memory / bus bridge.

---
 rtl/hatch_obi_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/hatch_obi_arbiter.sv
// hatch_obi_arbiter
// -----------------
// 2:1 OBI arbiter that merges the hatch core instruction-fetch port and data
// port onto one shared memory port.
// - Round-robin arbitration. A request that is presented but not granted is
//   locked, so the address phase stays stable until the grant.
// - A source-ID FIFO records the owner of each accepted transaction. In-order
//   responses are routed back to that owner.
//
// Handshake semantics: a request transfers on a cycle where mem_req_o and
// mem_gnt_i are both high. The winning port sees <port>_gnt_o high in that
// same cycle. A response is one mem_rvalid_i cycle. It is routed to the port
// at the head of the FIFO, and that FIFO entry is retired in the same cycle.
//
// Parameters
//   MAX_OUTSTANDING  accepted-but-unanswered transactions (1..8), FIFO depth
//
// Ports
//   clk_i, rst_i                         clock, synchronous active-high reset
//   instr_req_i/addr_i                   instruction request (read-only)
//   instr_gnt_o/rvalid_o/rdata_o/err_o   instruction grant and response
//   data_req_i/addr_i/we_i/be_i/wdata_i  data request
//   data_gnt_o/rvalid_o/rdata_o/err_o    data grant and response
//   mem_req_o/addr_o/we_o/be_o/wdata_o   shared request towards memory
//   mem_gnt_i/rvalid_i/rdata_i/err_i     shared grant and response from memory
//   protocol_err_o                       sticky: response seen with no
//                                        transaction outstanding
//
// Optional build macro HATCH_OBI_ARBITER_PERF_EN adds two counters:
//   contention_cnt_o  cycles where both ports request (one must lose)
//   stall_full_cnt_o  cycles where a request is blocked by a full FIFO
module hatch_obi_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,

  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,

  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,

  output logic        protocol_err_o
`ifdef HATCH_OBI_ARBITER_PERF_EN
  ,
  output logic [31:0] contention_cnt_o,
  output logic [31:0] stall_full_cnt_o
`endif
);

  localparam logic [0:0] SRC_INSTR = 1'b0;
  localparam logic [0:0] SRC_DATA  = 1'b1;
  localparam int         CNT_W     = $clog2(MAX_OUTSTANDING + 1);

  logic [0:0]                 sel;
  logic [0:0]                 lock_src;
  logic [0:0]                 rr_last;
  logic                       locked;
  logic [MAX_OUTSTANDING-1:0] fifo;      // bit 0 is the oldest entry
  logic [MAX_OUTSTANDING-1:0] fifo_next;
  logic [CNT_W-1:0]           count;
  logic [CNT_W-1:0]           count_next;
  logic                       full;
  logic                       empty;
  logic                       any_req;
  logic                       handshake;
  logic                       pop;
  logic                       resp_instr;
  logic                       resp_data;
  logic                       protocol_err;

  assign any_req = instr_req_i | data_req_i;
  assign full    = (count == CNT_W'(MAX_OUTSTANDING));
  assign empty   = (count == '0);

  // A locked source keeps ownership until its grant. Otherwise a lone
  // requester wins. On a tie, the port that did not win last time wins.
  always_comb begin
    sel = SRC_INSTR;
    if (locked)                          sel = lock_src;
    else if (instr_req_i && !data_req_i) sel = SRC_INSTR;
    else if (data_req_i && !instr_req_i) sel = SRC_DATA;
    else                                 sel = ~rr_last;
  end

  // A full FIFO blocks the request. This means a push never happens while
  // the FIFO is full.
  assign mem_req_o   = any_req & ~full & ~rst_i;
  assign handshake   = mem_req_o & mem_gnt_i;
  assign instr_gnt_o = handshake & (sel == SRC_INSTR);
  assign data_gnt_o  = handshake & (sel == SRC_DATA);

  always_comb begin
    if (sel == SRC_INSTR) begin
      mem_addr_o  = instr_addr_i;
      mem_we_o    = 1'b0;
      mem_be_o    = 4'hF;
      mem_wdata_o = '0;
    end else begin
      mem_addr_o  = data_addr_i;
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_wdata_o = data_wdata_i;
    end
  end

  // Source-ID FIFO. Pop first, then push. A push in the same cycle as a pop
  // lands in the slot freed by the shift, so the count is unchanged.
  assign pop = mem_rvalid_i & ~empty;

  always_comb begin
    fifo_next  = fifo;
    count_next = count;
    if (pop) begin
      fifo_next  = fifo >> 1;
      count_next = count - CNT_W'(1);
    end
    if (handshake) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (i == int'(count_next)) fifo_next[i] = sel;
      end
      count_next = count_next + CNT_W'(1);
    end
  end

  // Response routing. A response that arrives while the FIFO is empty goes
  // to neither port.
  assign resp_instr     = pop & (fifo[0] == SRC_INSTR) & ~rst_i;
  assign resp_data      = pop & (fifo[0] == SRC_DATA) & ~rst_i;
  assign instr_rvalid_o = resp_instr;
  assign instr_rdata_o  = resp_instr ? mem_rdata_i : 32'h0;
  assign instr_err_o    = resp_instr & mem_err_i;
  assign data_rvalid_o  = resp_data;
  assign data_rdata_o   = resp_data ? mem_rdata_i : 32'h0;
  assign data_err_o     = resp_data & mem_err_i;
  assign protocol_err_o = protocol_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      locked       <= 1'b0;
      lock_src     <= SRC_INSTR;
      rr_last      <= SRC_INSTR;
      fifo         <= '0;
      count        <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (handshake) begin
        locked  <= 1'b0;
        rr_last <= sel;
      end else if (mem_req_o) begin
        locked   <= 1'b1;
        lock_src <= sel;
      end
      fifo  <= fifo_next;
      count <= count_next;
      if (mem_rvalid_i && empty) protocol_err <= 1'b1;
    end
  end

`ifdef HATCH_OBI_ARBITER_PERF_EN
  // When both ports request, at most one is granted per cycle. Any
  // dual-request cycle therefore counts as contention.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      contention_cnt_o <= '0;
      stall_full_cnt_o <= '0;
    end else begin
      if (instr_req_i && data_req_i) contention_cnt_o <= contention_cnt_o + 32'd1;
      if (any_req && full)           stall_full_cnt_o <= stall_full_cnt_o + 32'd1;
    end
  end
`endif

endmodule
